// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle for the load/store unit.
// The pipeline drives through the master modport; the unit uses the slave modport.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, big-endian sub-word lanes,
// read-modify-write for sub-word stores, and a bounded wait on the data cache.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      req_if,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    output logic                  cache_memwrite,
    output logic                  cache_enable,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    input  logic                  cache_write_finished,
    input  logic                  cache_read_finished
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_error_q;
    logic [ADDR_WIDTH-1:0] cache_addr_q;
    logic [DATA_WIDTH-1:0] cache_wdata_q;
    logic                  cache_memwrite_q;
    logic                  cache_enable_q;

    logic                  fault_s;
    logic                  word_store_s;
    logic                  timeout_s;

    // Lane 0 is the most significant byte; the selected lane is right-justified.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[15:0]  = wd[15:0];
                else        r[31:16] = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Request classification for the accept decision.
    always_comb begin
        fault_s      = 1'b0;
        word_store_s = 1'b0;
        case (req_if.req_size)
            2'b00:   fault_s = 1'b0;
            2'b01:   fault_s = req_if.req_addr[0];
            2'b10:   fault_s = (req_if.req_addr[1:0] != 2'b00);
            default: fault_s = 1'b1;
        endcase
        if (req_if.req_write && (req_if.req_size == 2'b10)) word_store_s = 1'b1;
        else                                                 word_store_s = 1'b0;
    end

    assign timeout_s = (cnt_q == CW'(TIMEOUT - 1));

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            ready_q          <= 1'b1;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            off_q            <= 2'b00;
            wdata_q          <= '0;
            cnt_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_error_q     <= 1'b0;
            cache_addr_q     <= '0;
            cache_wdata_q    <= '0;
            cache_memwrite_q <= 1'b0;
            cache_enable_q   <= 1'b0;
        end else begin
            resp_valid_q   <= 1'b0;
            cache_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        ready_q  <= 1'b0;
                        write_q  <= req_if.req_write;
                        size_q   <= req_if.req_size;
                        signed_q <= req_if.req_signed;
                        off_q    <= req_if.req_addr[1:0];
                        wdata_q  <= req_if.req_wdata;
                        if (fault_s) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q          <= word_store_s ? WR_ISSUE : RD_ISSUE;
                            cache_enable_q   <= 1'b1;
                            cache_memwrite_q <= word_store_s;
                            cache_addr_q     <= {req_if.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            cache_wdata_q    <= word_store_s ? req_if.req_wdata : '0;
                        end
                    end
                end
                RD_ISSUE: begin
                    state_q <= RD_WAIT;
                    cnt_q   <= '0;
                end
                RD_WAIT: begin
                    if (cache_read_finished) begin
                        if (write_q) begin
                            // Sub-word store: write back the merged word at the same address.
                            state_q          <= WR_ISSUE;
                            cache_enable_q   <= 1'b1;
                            cache_memwrite_q <= 1'b1;
                            cache_wdata_q    <= store_merge(cache_read_data, size_q, off_q, wdata_q);
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b0;
                            resp_rdata_q <= load_extract(cache_read_data, size_q, off_q, signed_q);
                        end
                    end else if (timeout_s) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR_ISSUE: begin
                    state_q <= WR_WAIT;
                    cnt_q   <= '0;
                end
                WR_WAIT: begin
                    if (cache_write_finished || timeout_s) begin
                        state_q          <= RESP;
                        cache_memwrite_q <= 1'b0;
                        resp_valid_q     <= 1'b1;
                        resp_error_q     <= !cache_write_finished;
                        resp_rdata_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_if.req_ready  = ready_q;
    assign req_if.busy       = ~ready_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_rdata = resp_rdata_q;
    assign req_if.resp_error = resp_error_q;
    assign cache_addr        = cache_addr_q;
    assign cache_write_data  = cache_wdata_q;
    assign cache_memwrite    = cache_memwrite_q;
    assign cache_enable      = cache_enable_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural cache with programmable latency,
// response scoreboard, and directed scenarios for lanes, faults, timeout and reset.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    logic [31:0] cache_addr, cache_write_data, cache_read_data;
    logic        cache_memwrite, cache_enable, cache_write_finished, cache_read_finished;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_if(bus),
        .cache_addr(cache_addr), .cache_write_data(cache_write_data),
        .cache_memwrite(cache_memwrite), .cache_enable(cache_enable),
        .cache_read_data(cache_read_data), .cache_write_finished(cache_write_finished),
        .cache_read_finished(cache_read_finished)
    );

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } acc_t;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    acc_t acc_log[$];
    logic [31:0] mem [0:255];
    int   lat = 1;
    bit   mute = 1'b0;
    int   pend = 0;
    bit   pend_w = 1'b0;
    logic [31:0] rd_hold = 32'h0;
    int   en_count = 0;
    bit   prev_valid = 1'b0;

    // Cache model: latches each enabled access and answers after lat cycles.
    always @(negedge clk) begin
        cache_read_finished  = 1'b0;
        cache_write_finished = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (pend_w) cache_write_finished = 1'b1;
                    else begin
                        cache_read_finished = 1'b1;
                        cache_read_data     = rd_hold;
                    end
                end
            end
            if (cache_enable) begin
                en_count++;
                acc_log.push_back('{cache_memwrite, cache_addr, cache_write_data});
                if (cache_memwrite) mem[cache_addr[9:2]] = cache_write_data;
                else                rd_hold = mem[cache_addr[9:2]];
                pend_w = cache_memwrite;
                if (!mute) pend = lat;
            end
        end
    end

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            checks++;
            if (prev_valid) begin
                failures++;
                $display("FAIL resp_pulse: resp_valid high two cycles, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got rdata=%08h err=%0b, required no response",
                         bus.resp_rdata, bus.resp_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.resp_rdata !== e.rdata || bus.resp_error !== e.err) begin
                    failures++;
                    $display("FAIL resp_data: got rdata=%08h err=%0b, required rdata=%08h err=%0b",
                             bus.resp_rdata, bus.resp_error, e.rdata, e.err);
                end
            end
        end
        prev_valid = bus.resp_valid;
    end

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!bus.req_ready) begin
            failures++;
            $display("FAIL req_ready_wait: req_ready=0 after 40 cycles, required 1");
        end else begin
            drive(w, sz, sg, a, wd);
            exp_q.push_back('{er, ee});
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_rdata, bus.resp_error,
             cache_enable, cache_memwrite, cache_addr, cache_write_data} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL %s: ready=%0b busy=%0b rv=%0b rd=%08h err=%0b en=%0b mw=%0b addr=%08h wd=%08h, required 1 0 0 0 0 0 0 0 0",
                     name, bus.req_ready, bus.busy, bus.resp_valid, bus.resp_rdata, bus.resp_error,
                     cache_enable, cache_memwrite, cache_addr, cache_write_data);
        end
    endtask

    task automatic test_reset();
        #12 check_reset_vals("reset_values");
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_loads();
        mem[8'h40] = 32'h12F45678;
        acc_log.delete();
        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hFFFFFFF4, 1'b0);
        wait_done("load_sbyte");
        checks++;
        if (acc_log.size() != 1 || acc_log[0].w !== 1'b0 || acc_log[0].a !== 32'h100) begin
            failures++;
            $display("FAIL load_sbyte_access: %0d accesses, required one read at 00000100", acc_log.size());
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h00005678, 1'b0);
        wait_done("load_uhalf");
        do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h00000012, 1'b0);
        wait_done("load_ubyte0");
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h000012F4, 1'b0);
        wait_done("load_shalf0");
        lat = 3;
        do_req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'h12F45678, 1'b0);
        wait_done("load_word");
        lat = 1;
    endtask

    task automatic test_stores();
        mem[8'h80] = 32'hAABBCCDD;
        acc_log.delete();
        do_req(1'b1, 2'b00, 1'b0, 32'h203, 32'h00000011, 32'h0, 1'b0);
        wait_done("store_byte");
        checks++;
        if (acc_log.size() != 2 || acc_log[0].w !== 1'b0 || acc_log[0].a !== 32'h200 ||
            acc_log[1].w !== 1'b1 || acc_log[1].a !== 32'h200 || acc_log[1].d !== 32'hAABBCC11) begin
            failures++;
            $display("FAIL store_byte_access: %0d accesses mem=%08h, required read then write AABBCC11 at 00000200",
                     acc_log.size(), mem[8'h80]);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h200, 32'h12347788, 32'h0, 1'b0);
        wait_done("store_half");
        checks++;
        if (mem[8'h80] !== 32'h7788CC11) begin
            failures++;
            $display("FAIL store_half_mem: mem=%08h, required 7788CC11", mem[8'h80]);
        end
    endtask

    task automatic test_faults();
        int en0;
        en0 = en_count;
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        exp_q.push_back('{32'h0, 1'b1});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1) begin
            failures++;
            $display("FAIL misalign_resp: rv=%0b err=%0b, required 1 1", bus.resp_valid, bus.resp_error);
        end
        @(posedge clk);
        #1 checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL misalign_idle: req_ready=%0b, required 1", bus.req_ready);
        end
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        wait_done("reserved_size");
        do_req(1'b1, 2'b01, 1'b0, 32'h201, 32'h0, 32'h0, 1'b1);
        wait_done("misalign_half");
        checks++;
        if (en_count != en0) begin
            failures++;
            $display("FAIL fault_no_access: %0d cache enables, required 0", en_count - en0);
        end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 2'b10, 1'b0, 32'h204, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'hFFFFFF88, 1'b0);
        wait_done("back_to_back");
    endtask

    task automatic test_timeout();
        mute = 1'b1;
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        exp_q.push_back('{32'h0, 1'b1});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: resp_valid=%0b at 7 cycles, required 0", bus.resp_valid);
        end
        @(posedge clk);
        #1 checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_at_8: rv=%0b err=%0b, required 1 1", bus.resp_valid, bus.resp_error);
        end
        wait_done("timeout");
        mute = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        mute = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h208, 32'h55AA55AA);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 checks++;
        if (cache_memwrite !== 1'b1 || cache_addr !== 32'h208 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_wait_hold: mw=%0b addr=%08h busy=%0b, required 1 00000208 1",
                     cache_memwrite, cache_addr, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_mid_write");
        @(negedge clk) rst_n = 1'b1;
        mute = 1'b0;
        @(posedge clk);
        #1 checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: req_ready=%0b, required 1", bus.req_ready);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_done("post_reset_load");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        cache_read_data      = 32'h0;
        cache_read_finished  = 1'b0;
        cache_write_finished = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_timeout();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
